// File: rtl/multicycle_divider_pkg.sv
// Shared types and constants for the iterative integer divider.
package pipes;

  typedef enum logic {
    DIVOP = 1'b0,
    MODOP = 1'b1
  } divider_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam int DIV_WORD_BITS = 32;

endpackage

// File: rtl/multicycle_divider_prep.sv
// Combinational operand preparation: word-mode extension, magnitudes, signs
// and RISC-V special-case results (divide by zero, signed overflow).
module div_operand_prep
  import pipes::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             [WIDTH-1:0] a,
  input  logic             [WIDTH-1:0] b,
  input  divider_op_t                  op,
  input  logic                         is_signed,
  input  logic                         word,
  output logic             [WIDTH-1:0] a_mag,
  output logic             [WIDTH-1:0] b_mag,
  output logic                         quo_neg,
  output logic                         rem_neg,
  output logic                         special,
  output logic             [WIDTH-1:0] special_result
);

  function automatic logic [WIDTH-1:0] ext_word(input logic [DIV_WORD_BITS-1:0] v,
                                                input logic sgn);
    logic [WIDTH-1:0] r;
    r = '0;
    r[DIV_WORD_BITS-1:0] = v;
    for (int i = DIV_WORD_BITS; i < WIDTH; i++) r[i] = sgn & v[DIV_WORD_BITS-1];
    return r;
  endfunction

  logic [WIDTH-1:0] a_ext;
  logic [WIDTH-1:0] b_ext;
  logic [WIDTH-1:0] min_neg;
  logic [WIDTH-1:0] dividend_res;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             overflow;

  always_comb begin
    a_ext   = word ? ext_word(a[DIV_WORD_BITS-1:0], is_signed) : a;
    b_ext   = word ? ext_word(b[DIV_WORD_BITS-1:0], is_signed) : b;
    min_neg = word ? ext_word(32'h8000_0000, 1'b1) : {1'b1, {(WIDTH-1){1'b0}}};

    a_neg   = is_signed & a_ext[WIDTH-1];
    b_neg   = is_signed & b_ext[WIDTH-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    quo_neg = a_neg ^ b_neg;
    rem_neg = a_neg;

    // Word results are always sign-extended from bit 31, even for unsigned ops.
    dividend_res = word ? ext_word(a[DIV_WORD_BITS-1:0], 1'b1) : a;
    div_zero     = (b_ext == '0);
    overflow     = is_signed && (a_ext == min_neg) && (b_ext == '1);
    special      = div_zero | overflow;

    if (div_zero) begin
      special_result = (op == DIVOP) ? '1 : dividend_res;
    end else begin
      special_result = (op == DIVOP) ? dividend_res : '0;
    end
  end

endmodule

// File: rtl/multicycle_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, with word mode,
// single-cycle special cases, output backpressure and flush.
module multicycle_divider
  import pipes::*;
#(
  parameter int WIDTH   = 64,
  parameter bit WORD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  divider_op_t       op,
  input  logic              is_signed,
  input  logic              word,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result
);

  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] sext_word(input logic [DIV_WORD_BITS-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    r[DIV_WORD_BITS-1:0] = v;
    for (int i = DIV_WORD_BITS; i < WIDTH; i++) r[i] = v[DIV_WORD_BITS-1];
    return r;
  endfunction

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  divider_op_t      op_q, op_d;
  logic             word_q, word_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             word_eff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             quo_neg;
  logic             rem_neg;
  logic             special;
  logic [WIDTH-1:0] special_result;

  assign word_eff = WORD_EN ? word : 1'b0;

  div_operand_prep #(.WIDTH(WIDTH)) u_prep (
    .a              (a),
    .b              (b),
    .op             (op),
    .is_signed      (is_signed),
    .word           (word_eff),
    .a_mag          (a_mag),
    .b_mag          (b_mag),
    .quo_neg        (quo_neg),
    .rem_neg        (rem_neg),
    .special        (special),
    .special_result (special_result)
  );

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    op_d      = op_q;
    word_d    = word_q;
    result_d  = result_q;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while quotient bits enter at the LSB.
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dsr_q};
    fits    = ~diff[WIDTH];
    rem_n   = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n   = {quo_q[WIDTH-2:0], fits};
    quo_fix = quo_neg_q ? -quo_n : quo_n;
    rem_fix = rem_neg_q ? -rem_n : rem_n;
    sel     = (op_q == DIVOP) ? quo_fix : rem_fix;
    if (word_q) sel = sext_word(sel[DIV_WORD_BITS-1:0]);

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d      = op;
            word_d    = word_eff;
            quo_neg_d = quo_neg;
            rem_neg_d = rem_neg;
            dsr_d     = b_mag;
            rem_d     = '0;
            if (special) begin
              result_d = special_result;
              state_d  = DONE;
            end else begin
              // Left-align a 32-bit dividend so N steps consume exactly its bits.
              quo_d   = word_eff ? (a_mag << (WIDTH - DIV_WORD_BITS)) : a_mag;
              cnt_d   = word_eff ? CW'(DIV_WORD_BITS) : CW'(WIDTH);
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = sel;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      op_q      <= DIVOP;
      word_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      op_q      <= op_d;
      word_q    <= word_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Scoreboard bench for multicycle_divider (WIDTH=64): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_multicycle_divider;
  import pipes::*;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  divider_op_t  op;
  logic         is_signed;
  logic         word;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  multicycle_divider #(.WIDTH(W), .WORD_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .is_signed (is_signed),
    .word      (word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int fails  = 0;

  int           stall_cycles = 0;
  int           stall_left   = 0;
  bit           in_done      = 0;
  bit           post_hs      = 0;
  int           hs_count     = 0;
  logic [W-1:0] held;

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V divide/remainder semantics using native arithmetic.
  function automatic logic [W-1:0] refResult(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input divider_op_t o, input bit sgn, input bit wd);
    if (wd) begin
      logic [31:0] xs, ys, q, r;
      xs = x[31:0];
      ys = y[31:0];
      if (ys == 0) begin
        q = '1; r = xs;
      end else if (sgn && xs == 32'h8000_0000 && ys == 32'hFFFF_FFFF) begin
        q = xs; r = 0;
      end else if (sgn) begin
        q = $signed(xs) / $signed(ys); r = $signed(xs) % $signed(ys);
      end else begin
        q = xs / ys; r = xs % ys;
      end
      return sext32((o == MODOP) ? r : q);
    end else begin
      logic [63:0] q, r;
      if (y == 0) begin
        q = '1; r = x;
      end else if (sgn && x == 64'h8000_0000_0000_0000 && y == '1) begin
        q = x; r = 0;
      end else if (sgn) begin
        q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
      end else begin
        q = x / y; r = x % y;
      end
      return (o == MODOP) ? r : q;
    end
  endfunction

  function automatic int refLatency(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input bit sgn, input bit wd);
    if (wd) begin
      if (y[31:0] == 0 || (sgn && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
    if (y == 0 || (sgn && x == 64'h8000_0000_0000_0000 && y == '1)) return 1;
    return 65;
  endfunction

  // Monitor: pops on each new result, then checks stability and handshake.
  always @(negedge clk) begin
    if (reset) begin
      in_done   = 0;
      post_hs   = 0;
      out_ready = 1'b0;
    end else begin
      if (post_hs) begin
        checkOutput("idle_after_handshake", {62'd0, in_ready, out_valid}, 64'd2);
        post_hs = 0;
      end
      if (out_valid) begin
        checkOutput("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
        if (!in_done) begin
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_out_valid: got result %h, required no output", result);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("latency", 64'(cycle - e.acc), 64'(e.lat));
          end
          in_done    = 1;
          held       = result;
          stall_left = stall_cycles;
        end else begin
          checkOutput("result_stable", result, held);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          in_done   = 0;
          post_hs   = 1;
          hs_count++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  // Driver: call at a negedge; waits for in_ready, issues one request.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input divider_op_t o, input bit sgn, input bit wd,
                               input bit push, input bit use_const,
                               input logic [W-1:0] exp_const);
    int t;
    exp_t e;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      return;
    end
    a         = x;
    b         = y;
    op        = o;
    is_signed = sgn;
    word      = wd;
    in_valid  = 1'b1;
    if (push) begin
      e.res = use_const ? exp_const : refResult(x, y, o, sgn, wd);
      e.lat = refLatency(x, y, sgn, wd);
      e.acc = cycle;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while ((sb.size() != 0 || in_done || post_hs || !in_ready) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs0;
    logic [W-1:0] ra, rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    a         = '0;
    b         = '0;
    op        = DIVOP;
    is_signed = 1'b0;
    word      = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed cases with hand-derived results.
    applyStimulus(64'd100, 64'd7, DIVOP, 1, 0, 1, 1, 64'd14);
    applyStimulus(64'd100, 64'd7, MODOP, 1, 0, 1, 1, 64'd2);
    applyStimulus(-64'sd7, 64'd2, DIVOP, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(-64'sd7, 64'd2, MODOP, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(64'd5, 64'd0, DIVOP, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(64'd5, 64'd0, MODOP, 1, 0, 1, 1, 64'd5);
    applyStimulus(64'h8000_0000_0000_0000, '1, DIVOP, 1, 0, 1, 1, 64'h8000_0000_0000_0000);
    applyStimulus(64'h8000_0000_0000_0000, '1, MODOP, 1, 0, 1, 1, 64'd0);
    applyStimulus(64'hFFFF_FFFF, 64'd2, DIVOP, 0, 1, 1, 1, 64'h0000_0000_7FFF_FFFF);
    applyStimulus(64'h1_8000_0000, '1, DIVOP, 1, 1, 1, 1, 64'hFFFF_FFFF_8000_0000);
    waitIdle();

    // Backpressure: out_ready held low for 5 cycles after out_valid.
    stall_cycles = 5;
    hs0 = hs_count;
    applyStimulus(64'd100, 64'd7, DIVOP, 1, 0, 1, 1, 64'd14);
    waitIdle();
    checkOutput("handshake_count", 64'(hs_count - hs0), 64'd1);
    stall_cycles = 0;

    // Flush in the 10th BUSY cycle; no result may appear.
    applyStimulus(64'd100, 64'd7, DIVOP, 1, 0, 0, 0, '0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(negedge clk);
    applyStimulus(64'd100, 64'd7, DIVOP, 1, 0, 1, 1, 64'd14);
    waitIdle();

    // Reset mid-BUSY abandons the operation and clears the outputs.
    applyStimulus(64'd1000, 64'd3, DIVOP, 0, 0, 0, 0, '0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midbusy_reset_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("midbusy_reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midbusy_reset_result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_midbusy_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (70) @(negedge clk);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      int pa, pb;
      bit sgn, wd;
      divider_op_t o;
      sgn = 1'($urandom_range(0, 1));
      wd  = 1'($urandom_range(0, 1));
      o   = $urandom_range(0, 1) ? MODOP : DIVOP;
      pa  = $urandom_range(0, 5);
      pb  = $urandom_range(0, 5);
      ra  = {$urandom, $urandom};
      if (pa == 0) ra = wd ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
      else if (pa == 1) ra = 64'($urandom);
      case (pb)
        0:       rb = wd ? {$urandom, 32'h0} : 64'd0;
        1:       rb = wd ? {$urandom, 32'hFFFF_FFFF} : '1;
        2:       rb = 64'($urandom_range(1, 20));
        3:       rb = 64'($urandom);
        default: rb = {$urandom, $urandom};
      endcase
      stall_cycles = $urandom_range(0, 3);
      applyStimulus(ra, rb, o, sgn, wd, 1, 0, '0);
    end
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_divider.md
# multicycle_divider

Iterative, parametrised radix-2 integer divider serving the execute stage's DIV/DIVU/MOD/MODU and their 32-bit word forms. It accepts one operation per valid/ready handshake and computes one quotient bit per cycle. It presents a held result under output backpressure and can be flushed mid-operation on a pipeline redirect. It generalises the single-width divider to an arbitrary datapath width, adds a word mode with early termination, and adds single-cycle special-case handling.

## Interface
Parameters:
- WIDTH, 64: datapath width in bits; must be a power of two, at least 32.
- WORD_EN, 1: enables word mode (32-bit operation, result sign-extended to WIDTH); when 0, `word` is ignored.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- Clocking: one clock; reset is synchronous and active-high.
- in_valid  in  1  operation request
- in_ready  out  1  divider can accept
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- op  in  divider_op_t  DIVOP (quotient) or MODOP (remainder)
- is_signed  in  1  signed operands
- word  in  1  word mode
- flush  in  1  discard any operation in progress
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  quotient or remainder

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && !flush, the block latches the operands and control.
  - N = 32 in word mode, otherwise WIDTH.
  - In word mode the operands are the low 32 bits, sign-extended when signed and zero-extended when unsigned.
- Special cases are detected at accept and go IDLE→DONE directly. Results follow RISC-V:
  - b==0: quotient = all ones; remainder = dividend (word mode: low 32 bits sign-extended).
  - Signed overflow (dividend = most negative N-bit value, b = -1): quotient = dividend; remainder = 0.
- Normal case, IDLE→BUSY:
  - Magnitudes are taken for signed operands.
  - The counter is loaded with N.
  - Each BUSY cycle performs one restoring shift-subtract step and decrements the counter.
- At counter==1 the final step also applies sign fixup and result selection, then BUSY→DONE.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - In word mode the result is sign-extended from bit 31.
- DONE:
  - out_valid=1 and result stays stable.
  - On out_ready the block returns to IDLE.
  - A new request is not accepted in the same cycle as the DONE→IDLE transition.
- Flush:
  - In any state, flush forces IDLE on the next edge and discards the operation.
  - Flush has priority over accept, over the BUSY step, and over the out_ready handshake.
- Reset:
  - State=IDLE; out_valid=0; result=0; all internal registers are cleared.
  - in_ready=0 while reset is asserted.
  - A reset mid-BUSY or mid-DONE abandons the operation.

## Timing
- Accept edge E0. Normal operations perform N steps at E1..EN. out_valid is high from the cycle after EN, giving a latency of N+1 cycles from accept to out_valid.
- Special cases: out_valid is high in the cycle after E0 (latency 1).
- Back-to-back issue: the next accept can happen no earlier than the cycle after the out_ready handshake.
- in_ready is asserted only in IDLE. out_valid is asserted only in DONE.
- result is registered: no combinational path from inputs to result.
- Counter width: $clog2(WIDTH+1).

## Structure
- Package `pipes`:
  - reuse `divider_op_t`;
  - add `div_state_t` (IDLE, BUSY, DONE);
  - add the constant `DIV_WORD_BITS = 32`.
- Sub-module `div_operand_prep` (combinational):
  - word-mode truncation and extension;
  - magnitude computation;
  - sign capture;
  - special-case detect;
  - special-case result generation.

## Test plan
All scenarios use WIDTH=64.
- Basic signed: a=100, b=7, signed DIVOP → 14 after 65 cycles. The same operands with MODOP → 2.
- Negative: a=-7, b=2, signed. DIVOP → 0xFFFF_FFFF_FFFF_FFFD. MODOP → 0xFFFF_FFFF_FFFF_FFFF.
- Special cases, each with out_valid one cycle after accept:
  - b=0, a=5: DIVOP → all ones; MODOP → 5.
  - a=0x8000_0000_0000_0000, b=-1, signed: DIVOP → 0x8000_0000_0000_0000; MODOP → 0.
- Word mode:
  - a=0xFFFF_FFFF, b=2, unsigned, word, DIVOP → 0x0000_0000_7FFF_FFFF, with latency 33.
  - a=0x1_8000_0000, b=-1, signed, word → 0xFFFF_FFFF_8000_0000 (overflow path).
- Backpressure: hold out_ready low for 5 cycles after out_valid. result stays stable, in_ready=0, exactly one handshake occurs, and IDLE is reached on the following edge.
- Flush and reset:
  - Flush in the 10th BUSY cycle: IDLE on the next edge, out_valid never asserts, and a subsequent 100/7 returns 14.
  - Reset asserted mid-BUSY: all outputs return to their reset values.
